alarm_arm_sequencer: RTL



---
 rtl/alarm_pkg.sv | 30 +++
 rtl/tick_consumer.sv | 24 ++
 rtl/alarm_arm_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared alarm definitions: FSM state codes and the 20 ms tick timing constants
// used by both the alarm timer and the arming sequencer.
package alarm_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        DISARMED = 3'd0,
        EXIT     = 3'd1,
        ARMED    = 3'd2,
        ENTRY    = 3'd3,
        ALARM    = 3'd4
    } state_t;

    // The timer derives its tick period from these, so delays in seconds stay exact.
    localparam int CLK_HZ      = 50_000_000;
    localparam int TICK_MS     = 20;
    localparam int TICK_CLKS   = (CLK_HZ / 1000) * TICK_MS;
    localparam int TICKS_PER_S = 1000 / TICK_MS;

    localparam int DEFAULT_CNT_W         = 14;
    localparam int DEFAULT_EXIT_TICKS    = 30 * TICKS_PER_S;
    localparam int DEFAULT_ENTRY_TICKS   = 15 * TICKS_PER_S;
    localparam int DEFAULT_ALARM_TICKS   = 180 * TICKS_PER_S;

    function automatic logic is_armed_state(input state_t s);
        return (s == EXIT) || (s == ARMED) || (s == ENTRY);
    endfunction

endpackage

// File: rtl/tick_consumer.sv
// Consumer side of the latched tick handshake: acknowledges each tick once and
// strobes tick_seen in the cycle the tick is taken.
module tick_consumer (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic tick_ack,
    output logic tick_seen
);

    // Handshake: a tick is taken in any cycle with tick=1 and tick_ack=0; tick_ack
    // is then high for exactly the next cycle, during which tick is not taken again.
    // A producer still holding tick in the cycle after tick_ack delivers a new tick.
    assign tick_seen = tick & ~tick_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_ack <= 1'b0;
        end else begin
            tick_ack <= tick_seen;
        end
    end

endmodule

// File: rtl/alarm_arm_sequencer.sv
// Alarm arming sequencer: consumes 20 ms ticks and runs the exit-delay / armed /
// entry-delay / siren state machine with a shared countdown register.
module alarm_arm_sequencer
    import alarm_pkg::*;
#(
    parameter int CNT_W       = DEFAULT_CNT_W,
    parameter int EXIT_TICKS  = DEFAULT_EXIT_TICKS,
    parameter int ENTRY_TICKS = DEFAULT_ENTRY_TICKS,
    parameter int ALARM_TICKS = DEFAULT_ALARM_TICKS
) (
    input  logic               clock50,
    input  logic               Mr,
    input  logic               tick,
    output logic               tick_ack,
    input  logic               arm_req,
    input  logic               disarm_req,
    input  logic               sensor,
    output logic [STATE_W-1:0] state,
    output logic               armed_led,
    output logic               siren,
    output logic [CNT_W-1:0]   countdown
);

    localparam logic [CNT_W-1:0] EXIT_LOAD  = CNT_W'(EXIT_TICKS);
    localparam logic [CNT_W-1:0] ENTRY_LOAD = CNT_W'(ENTRY_TICKS);
    localparam logic [CNT_W-1:0] ALARM_LOAD = CNT_W'(ALARM_TICKS);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic             tick_seen;
    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick_dec;
    logic             cnt_last;

    tick_consumer u_tick_consumer (
        .clk       (clock50),
        .rst       (Mr),
        .tick      (tick),
        .tick_ack  (tick_ack),
        .tick_seen (tick_seen)
    );

    // A counter already at zero ignores ticks rather than wrapping.
    assign tick_dec = tick_seen && (cnt_r != '0);
    assign cnt_last = (cnt_r == CNT_ONE);

    always_comb begin
        state_nxt = state_r;
        cnt_nxt   = cnt_r;
        if (disarm_req) begin
            state_nxt = DISARMED;
            cnt_nxt   = '0;
        end else begin
            case (state_r)
                DISARMED: begin
                    if (arm_req) begin
                        state_nxt = EXIT;
                        cnt_nxt   = EXIT_LOAD;
                    end
                end
                EXIT: begin
                    if (tick_dec) begin
                        if (cnt_last) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_r - CNT_ONE;
                        end
                    end
                end
                ARMED: begin
                    if (sensor) begin
                        state_nxt = ENTRY;
                        cnt_nxt   = ENTRY_LOAD;
                    end
                end
                ENTRY: begin
                    if (tick_dec) begin
                        if (cnt_last) begin
                            state_nxt = ALARM;
                            cnt_nxt   = ALARM_LOAD;
                        end else begin
                            cnt_nxt = cnt_r - CNT_ONE;
                        end
                    end
                end
                ALARM: begin
                    // Siren timeout re-arms; a sensor still active re-enters ENTRY from ARMED.
                    if (tick_dec) begin
                        if (cnt_last) begin
                            state_nxt = ARMED;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt_r - CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_nxt = DISARMED;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock50 or posedge Mr) begin
        if (Mr) begin
            state_r   <= DISARMED;
            cnt_r     <= '0;
            armed_led <= 1'b0;
            siren     <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            armed_led <= is_armed_state(state_nxt);
            siren     <= (state_nxt == ALARM);
        end
    end

    assign state     = state_r;
    assign countdown = cnt_r;

endmodule
